// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage driving the IF/ID register: owns the PC, issues one
// outstanding req/ack fetch at a time, holds the result until IF/ID takes it.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        IF_ID_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        IF_flush,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} fetchState_e;

  fetchState_e state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] pcOut_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] pcInc_d;
  logic [31:0] target_d;

  assign pcInc_d  = pc_q + 32'd4;
  assign target_d = {branch_target[31:2], 2'b00};

  // A redirect outranks both the memory response and the IF/ID write enable.
  // An in-flight request can never be withdrawn, so a redirect that arrives
  // before its ack parks in DROP and reissues once the stale data returns.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
      pcOut_q <= 32'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else if (branch_taken) begin
      pc_q    <= target_d;
      valid_q <= 1'b0;
      unique case (state_q)
        WAIT: begin
          if (imem_ack) begin
            req_q   <= 1'b1;
            addr_q  <= target_d;
            state_q <= WAIT;
          end else begin
            state_q <= DROP;
          end
        end
        DROP: begin
          state_q <= DROP;
        end
        default: begin
          req_q   <= 1'b1;
          addr_q  <= target_d;
          state_q <= WAIT;
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          req_q   <= 1'b1;
          addr_q  <= pc_q;
          state_q <= WAIT;
        end
        WAIT: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            pcOut_q <= addr_q;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (IF_ID_Write) begin
            pc_q    <= pcInc_d;
            req_q   <= 1'b1;
            addr_q  <= pcInc_d;
            valid_q <= 1'b0;
            state_q <= WAIT;
          end
        end
        DROP: begin
          if (imem_ack) begin
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            state_q <= WAIT;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign pc_out      = pcOut_q;
  assign instr_valid = valid_q;
  assign instr_out   = valid_q ? instr_q : NOP_INSTR;
  assign IF_flush    = branch_taken;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: two instances (default and wrapping RESET_PC)
// driven by a latency-programmable memory and checked against a fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        IF_ID_Write;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        reqA, validA, flushA;
  logic [31:0] addrA, pcA, instrA;
  logic        reqB, validB, flushB;
  logic [31:0] addrB, pcB, instrB;

  always #5 clock = ~clock;

  if_fetch_unit dutA (
    .clock(clock), .reset_n(reset_n),
    .imem_req(reqA), .imem_addr(addrA), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IF_ID_Write(IF_ID_Write), .branch_taken(branch_taken), .branch_target(branch_target),
    .IF_flush(flushA), .pc_out(pcA), .instr_out(instrA), .instr_valid(validA)
  );

  if_fetch_unit #(.RESET_PC(WRAP_PC)) dutB (
    .clock(clock), .reset_n(reset_n),
    .imem_req(reqB), .imem_addr(addrB), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IF_ID_Write(IF_ID_Write), .branch_taken(branch_taken), .branch_target(branch_target),
    .IF_flush(flushB), .pc_out(pcB), .instr_out(instrB), .instr_valid(validB)
  );

  // Transaction view of the fetch stage: an outstanding request, whether its
  // data is already known to be stale, the presented instruction and next PC.
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] nextPc;
    logic        stale;
  } fetchModel_t;

  fetchModel_t mA, mB;
  int compared;
  int mismatched;
  int age;
  int lat;
  bit randLat;

  function automatic fetchModel_t modelStep(input fetchModel_t m, input logic [31:0] resetPc,
                                            input logic rstN, input logic br, input logic [31:0] tgt,
                                            input logic ack, input logic [31:0] rdata, input logic wr);
    fetchModel_t n;
    n = m;
    if (!rstN) begin
      n.req = 1'b0; n.addr = 32'd0; n.valid = 1'b0; n.pc = 32'd0;
      n.instr = 32'd0; n.nextPc = resetPc; n.stale = 1'b0;
    end else if (br) begin
      n.nextPc = tgt & ~32'd3;
      n.valid  = 1'b0;
      if (m.req && (m.stale || !ack)) begin
        n.stale = 1'b1;
      end else begin
        n.req = 1'b1; n.addr = tgt & ~32'd3; n.stale = 1'b0;
      end
    end else if (m.req && ack) begin
      if (m.stale) begin
        n.addr = m.nextPc; n.stale = 1'b0;
      end else begin
        n.valid = 1'b1; n.pc = m.addr; n.instr = rdata; n.req = 1'b0;
      end
    end else if (!m.req && !m.valid) begin
      n.req = 1'b1; n.addr = m.nextPc;
    end else if (m.valid && wr) begin
      n.nextPc = m.nextPc + 32'd4;
      n.req = 1'b1; n.addr = m.nextPc + 32'd4; n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkBit("A.req", reqA, mA.req);
    checkVal("A.addr", addrA, mA.addr);
    checkBit("A.valid", validA, mA.valid);
    checkVal("A.pc", pcA, mA.pc);
    checkVal("A.instr", instrA, mA.valid ? mA.instr : NOP);
    checkBit("B.req", reqB, mB.req);
    checkVal("B.addr", addrB, mB.addr);
    checkBit("B.valid", validB, mB.valid);
    checkVal("B.pc", pcB, mB.pc);
    checkVal("B.instr", instrB, mB.valid ? mB.instr : NOP);
  endtask

  task automatic applyStimulus(input logic rst, input logic br, input logic [31:0] tgt,
                               input logic ack, input logic [31:0] rdata, input logic wr);
    logic prevReq;
    reset_n = rst; branch_taken = br; branch_target = tgt;
    imem_ack = ack; imem_rdata = rdata; IF_ID_Write = wr;
    #1;
    checkBit("A.flush", flushA, br);
    checkBit("B.flush", flushB, br);
    prevReq = mA.req;
    @(posedge clock);
    mA = modelStep(mA, 32'h0, rst, br, tgt, ack, rdata, wr);
    mB = modelStep(mB, WRAP_PC, rst, br, tgt, ack, rdata, wr);
    if (mA.req) age = (prevReq && !ack) ? age + 1 : 1;
    else age = 0;
    if (randLat && age == 1) lat = $urandom_range(0, 3);
    #1;
    checkOutput();
  endtask

  // Memory acks once a request has been visible for more than 'lat' cycles.
  task automatic memCycle(input logic br, input logic [31:0] tgt, input logic wr,
                          input logic [31:0] rdata);
    applyStimulus(1'b1, br, tgt, mA.req && (age > lat), rdata, wr);
  endtask

  initial begin
    logic [31:0] savedPc;
    int n;
    compared = 0; mismatched = 0; age = 0; lat = 1; randLat = 0;
    mA = '0; mB = '0;

    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkBit("rst.req", reqA, 1'b0);
    checkVal("rst.addr", addrA, 32'd0);
    checkVal("rst.pc", pcA, 32'd0);
    checkVal("rst.instr", instrA, NOP);

    // zero-wait memory, always consuming
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    checkBit("s1.firstReq", reqA, 1'b1);
    checkVal("s1.firstAddr", addrA, 32'd0);
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    checkBit("s1.notYetValid", validA, 1'b0);
    checkVal("s1.nopWhileInvalid", instrA, NOP);
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    checkBit("s1.validCycle3", validA, 1'b1);
    checkVal("s1.pcCycle3", pcA, 32'd0);
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    checkVal("s1.nextAddr", addrA, 32'd4);

    // stall four cycles in HOLD
    n = 0;
    while (!mA.valid && n < 10) begin
      memCycle(1'b0, 32'd0, 1'b0, 32'h0050_0093);
      n++;
    end
    checkBit("s2.reachedHold", mA.valid, 1'b1);
    checkVal("s2.pc", pcA, 32'd4);
    savedPc = mA.pc;
    for (int i = 0; i < 4; i++) begin
      memCycle(1'b0, 32'd0, 1'b0, $urandom);
      checkVal("s2.instrStable", instrA, 32'h0050_0093);
      checkVal("s2.pcStable", pcA, savedPc);
      checkBit("s2.validStable", validA, 1'b1);
      checkBit("s2.reqLow", reqA, 1'b0);
    end
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    checkVal("s2.releaseAddr", addrA, savedPc + 32'd4);

    // redirect while a 3-cycle fetch is outstanding
    lat = 3;
    memCycle(1'b1, 32'h0000_0103, 1'b1, $urandom);
    n = 0;
    while (mA.stale && n < 10) begin
      checkVal("s3.addrHeld", addrA, 32'd8);
      checkBit("s3.reqHeld", reqA, 1'b1);
      memCycle(1'b0, 32'd0, 1'b1, $urandom);
      n++;
    end
    checkVal("s3.newAddr", addrA, 32'h0000_0100);
    checkBit("s3.discarded", validA, 1'b0);

    // redirect in the same cycle as the ack
    lat = 1;
    n = 0;
    while (!(mA.req && !mA.stale && age > lat) && n < 10) begin
      memCycle(1'b0, 32'd0, 1'b1, $urandom);
      n++;
    end
    checkBit("s4.ackPending", mA.req && age > lat, 1'b1);
    memCycle(1'b1, 32'h0000_0A40, 1'b1, $urandom);
    checkBit("s4.notPresented", validA, 1'b0);
    checkVal("s4.targetAddr", addrA, 32'h0000_0A40);

    // two redirects while dropping
    lat = 3;
    memCycle(1'b1, 32'h0000_0200, 1'b1, $urandom);
    memCycle(1'b1, 32'h0000_0300, 1'b1, $urandom);
    n = 0;
    while (mA.stale && n < 10) begin
      checkVal("s5.addrHeld", addrA, 32'h0000_0A40);
      memCycle(1'b0, 32'd0, 1'b1, $urandom);
      n++;
    end
    checkVal("s5.newestTarget", addrA, 32'h0000_0300);
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    checkVal("s5.singleRequest", addrA, 32'h0000_0300);

    // randomized traffic with varying memory latency
    randLat = 1;
    for (int i = 0; i < 400; i++) begin
      memCycle($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 2) != 0, $urandom);
    end
    randLat = 0;

    // PC wrap and reset during an outstanding request
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    lat = 1;
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    checkVal("s6.wrapFirstAddr", addrB, WRAP_PC);
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    checkVal("s6.wrapPc", pcB, WRAP_PC);
    memCycle(1'b0, 32'd0, 1'b1, $urandom);
    checkVal("s6.wrapNextAddr", addrB, 32'd0);
    checkBit("s6.wrapReq", reqB, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkBit("s6.reqDropped", reqB, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    checkBit("s6.lateAckIgnored", validB, 1'b0);
    checkVal("s6.restartAddr", addrB, WRAP_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that drives the IF/ID pipeline register. It is the producer side of that register's interface and supplies pc, instruction and the IF flush request.
- Owns the PC register.
- Issues single-outstanding requests to instruction memory over a req/ack handshake.
- Holds each fetched instruction until the hazard unit allows the IF/ID write (IF_ID_Write).
- Handles branch redirects, including ones that arrive while a fetch is still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INSTR, 32'h0000_0013, bubble presented on instr_out whenever instr_valid=0 (addi x0,x0,0)

Ports:
clock  input  1  system clock, all state updates on posedge
reset_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request, registered
imem_addr  output  32  fetch address, registered, word-aligned
imem_ack  input  1  memory response strobe; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction
IF_ID_Write  input  1  hazard-unit write enable; 1 = IF/ID captures this cycle
branch_taken  input  1  redirect request from branch resolution
branch_target  input  32  redirect address; bits [1:0] forced to 0
IF_flush  output  1  combinational copy of branch_taken, to the IF/ID flush input
pc_out  output  32  PC of the presented instruction
instr_out  output  32  presented instruction; NOP_INSTR when instr_valid=0
instr_valid  output  1  instr_out holds a real fetched instruction

Behaviour:
- Reset, reset_n=0 sampled at posedge:
  - state=IDLE, pc_reg=RESET_PC
  - imem_req=0, imem_addr=0
  - pc_out=0, instr_valid=0, so instr_out=NOP_INSTR
  - IF_flush still follows branch_taken combinationally.
- Reset mid-request: imem_req drops at that edge; a late imem_ack is ignored because IDLE ignores ack.
- States: IDLE, WAIT (request outstanding), HOLD (instruction presented), DROP (outstanding request must be discarded).
- IDLE, no branch: next edge imem_req<=1, imem_addr<=pc_reg, ->WAIT.
- Request rule: while imem_req=1, imem_addr is stable until the cycle imem_ack=1. At most one outstanding request. Requests are never withdrawn early.
- WAIT, imem_ack=1, no branch:
  - instr_out<=imem_rdata, pc_out<=imem_addr, instr_valid<=1
  - imem_req<=0, ->HOLD
  - Ack-to-valid latency is 1 cycle.
- HOLD, IF_ID_Write=1 (instruction consumed this edge):
  - pc_reg<=pc_reg+4, imem_req<=1, imem_addr<=pc_reg+4
  - instr_valid<=0, ->WAIT
  - With zero-wait memory this gives a throughput of 1 instruction per 3 cycles.
- HOLD, IF_ID_Write=0: all outputs held (stall).
- IF_ID_Write is ignored in IDLE/WAIT/DROP. IF/ID then latches the NOP bubble.
- branch_taken=1 has priority over IF_ID_Write and ack. In every case pc_reg<=branch_target&~3 and instr_valid<=0.
  - IDLE, HOLD, or WAIT with imem_ack=1: issue target next edge (imem_req<=1, imem_addr<=target), ->WAIT. Any same-cycle rdata is discarded.
  - WAIT with imem_ack=0: keep imem_req/imem_addr unchanged, ->DROP.
  - DROP: pc_reg updated to the newest target, stay DROP.
- DROP, imem_ack=1, no branch: discard rdata, imem_req<=1, imem_addr<=pc_reg, ->WAIT.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

Test Plan:
1. Reset, zero-wait memory (ack the cycle after req):
   - First request at cycle 1 with imem_addr=0.
   - instr_valid=1 with pc_out=0 at cycle 3.
   - Next imem_addr=4.
   - instr_out=NOP_INSTR while invalid.
2. Stall: hold IF_ID_Write=0 for 4 cycles in HOLD with rdata=32'h00500093.
   - instr_out, pc_out and instr_valid stable throughout; imem_req=0.
   - Release -> imem_addr=pc_out+4 next cycle.
3. Redirect in WAIT with a 3-cycle memory latency, branch_taken at target 32'h0000_0103:
   - imem_addr held at the old value until ack; that ack's rdata is discarded.
   - Next request addr=32'h0000_0100.
   - IF_flush=1 only in the branch cycle.
4. Branch in the same cycle as ack: rdata not presented (instr_valid stays 0), next imem_addr=target.
5. Two branches (0x200, then 0x300) while in DROP: single request issued afterward, to 0x300.
6. Wrap: RESET_PC=32'hFFFF_FFFC, consume one instruction -> next imem_addr=0. Then assert reset_n=0 while imem_req=1: imem_req=0 next edge and a late ack is ignored.
